// File: rtl/regfile_mp.sv
// Multi-port register file for the RV32I core with a post-reset zeroing sweep,
// optional write-to-read bypass and a per-register busy scoreboard for RAW hazards.
module regfile_mp #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic [NREAD*AW-1:0]     AddrR,
   output logic [NREAD*XLEN-1:0]   DataR,
   output logic [NREAD-1:0]        BusyR,
   input  logic                    WEn,
   input  logic [AW-1:0]           AddrW,
   input  logic [XLEN-1:0]         DataW,
   input  logic                    ResvEn,
   input  logic [AW-1:0]           AddrRv,
   output logic                    Ready
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state;
   logic [AW-1:0]     cnt;
   logic [NREGS-1:0]  busy;
   logic [NREGS-1:0]  busy_nxt;
   logic [XLEN-1:0]   mem [NREGS];
   logic              run;
   logic              wr_ok;
   logic              resv_ok;

   assign run     = (state == RUN);
   assign wr_ok   = run && WEn    && !((ZERO_REG != 0) && (AddrW  == '0));
   assign resv_ok = run && ResvEn && !((ZERO_REG != 0) && (AddrRv == '0));
   assign Ready   = run;

   // A reserve issued alongside a write to the same register wins: it is a newer producer.
   always_comb begin
      busy_nxt = busy;
      if (wr_ok)
         busy_nxt[AddrW] = 1'b0;
      if (resv_ok)
         busy_nxt[AddrRv] = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
         busy  <= '0;
      end else if (!run) begin
         cnt <= cnt + AW'(1);
         if (cnt == AW'(NREGS - 1))
            state <= RUN;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Storage is deliberately not reset; the CLEAR sweep zeroes it one entry per cycle.
   always_ff @(posedge Clk) begin
      if (Rst_n) begin
         if (!run)
            mem[cnt] <= '0;
         else if (wr_ok)
            mem[AddrW] <= DataW;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;

      assign addr = AddrR[i*AW +: AW];

      always_comb begin
         data = mem[addr];
         if ((BYPASS != 0) && wr_ok && (AddrW == addr))
            data = DataW;
         if (((ZERO_REG != 0) && (addr == '0)) || !run)
            data = '0;
      end

      assign DataR[i*XLEN +: XLEN] = data;
      assign BusyR[i]              = run & busy[addr];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 3-port bypassing instance and a 2-port
// non-bypassing instance share clock, reset, write and reserve stimulus.
module tb_regfile_mp;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3*AW-1:0]   addr_r;
   logic [3*XLEN-1:0] data_r;
   logic [2:0]        busy_r;
   logic [2*AW-1:0]   addr_rb;
   logic [2*XLEN-1:0] data_rb;
   logic [1:0]        busy_rb;
   logic              wen;
   logic [AW-1:0]     addr_w;
   logic [XLEN-1:0]   data_w;
   logic              resv_en;
   logic [AW-1:0]     addr_rv;
   logic              ready;
   logic              ready_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .Clk(clk), .Rst_n(rst_n), .AddrR(addr_r), .DataR(data_r), .BusyR(busy_r),
      .WEn(wen), .AddrW(addr_w), .DataW(data_w), .ResvEn(resv_en), .AddrRv(addr_rv),
      .Ready(ready)
   );

   regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .Clk(clk), .Rst_n(rst_n), .AddrR(addr_rb), .DataR(data_rb), .BusyR(busy_rb),
      .WEn(wen), .AddrW(addr_w), .DataW(data_w), .ResvEn(resv_en), .AddrRv(addr_rv),
      .Ready(ready_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wen = 1'b0; resv_en = 1'b0;
      addr_r = '0; addr_rb = '0; addr_w = '0; addr_rv = '0; data_w = '0;
      tick(); tick();
      n_cmp++;
      if (ready !== 1'b0 || ready_b !== 1'b0) begin
         n_err++; $display("FAIL reset_ready: got %b/%b want 0/0", ready, ready_b);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         #1;
         n_cmp++;
         if (ready !== 1'b0 || data_r !== '0 || busy_r !== 3'b000) begin
            n_err++;
            $display("FAIL clear_outputs cyc %0d: ready=%b data=%h busy=%b want 0/0/0", k, ready, data_r, busy_r);
         end
         tick();
      end
      n_cmp++;
      if (ready !== 1'b1 || ready_b !== 1'b1) begin
         n_err++; $display("FAIL ready_rise: got %b/%b want 1/1", ready, ready_b);
      end
      for (int r = 0; r < 32; r++) begin
         addr_r = {10'd0, AW'(r)};
         addr_rb = {AW'(r), AW'(r)};
         #1;
         n_cmp++;
         if (data_r[31:0] !== 32'h0 || busy_r[0] !== 1'b0 || data_rb !== '0 || busy_rb !== 2'b00) begin
            n_err++;
            $display("FAIL cleared_reg x%0d: data=%h busy=%b data_b=%h want 0", r, data_r[31:0], busy_r[0], data_rb);
         end
      end
   endtask

   task automatic test_mid_clear();
      rst_n = 1'b0; tick();
      rst_n = 1'b1;
      for (int k = 0; k < 9; k++) tick();
      rst_n = 1'b0; tick();
      rst_n = 1'b1;
      wen = 1'b1; addr_w = 5'd5; data_w = 32'hDEADBEEF;
      resv_en = 1'b1; addr_rv = 5'd6;
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k == 32) begin
            wen = 1'b0; resv_en = 1'b0;
         end
         n_cmp++;
         if (ready !== (k == 32)) begin
            n_err++; $display("FAIL mid_clear_ready cyc %0d: got %b want %b", k, ready, (k == 32));
         end
      end
      addr_r = {5'd0, 5'd6, 5'd5};
      #1;
      n_cmp++;
      if (data_r[31:0] !== 32'h0 || busy_r[1] !== 1'b0) begin
         n_err++; $display("FAIL clear_ignores_ops: x5=%h busy_x6=%b want 0/0", data_r[31:0], busy_r[1]);
      end
   endtask

   task automatic test_bypass();
      wen = 1'b1; addr_w = 5'd7; data_w = 32'h12345678;
      addr_r = {5'd0, 5'd0, 5'd7};
      addr_rb = {5'd0, 5'd7};
      #1;
      n_cmp++;
      if (data_r[31:0] !== 32'h12345678) begin
         n_err++; $display("FAIL bypass_same_cycle: got %h want 12345678", data_r[31:0]);
      end
      n_cmp++;
      if (data_rb[31:0] !== 32'h0) begin
         n_err++; $display("FAIL nobypass_same_cycle: got %h want 00000000", data_rb[31:0]);
      end
      tick();
      wen = 1'b0;
      #1;
      n_cmp++;
      if (data_rb[31:0] !== 32'h12345678 || data_r[31:0] !== 32'h12345678) begin
         n_err++; $display("FAIL write_next_cycle: got %h/%h want 12345678", data_r[31:0], data_rb[31:0]);
      end
   endtask

   task automatic test_zero_reg();
      wen = 1'b1; addr_w = 5'd0; data_w = 32'hFFFFFFFF;
      resv_en = 1'b1; addr_rv = 5'd0;
      addr_r = {5'd0, 5'd0, 5'd0};
      addr_rb = {5'd0, 5'd0};
      #1;
      n_cmp++;
      if (data_r[31:0] !== 32'h0 || busy_r[0] !== 1'b0) begin
         n_err++; $display("FAIL x0_same_cycle: data=%h busy=%b want 0/0", data_r[31:0], busy_r[0]);
      end
      tick();
      wen = 1'b0; resv_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (data_r[31:0] !== 32'h0 || busy_r[0] !== 1'b0 || data_rb[31:0] !== 32'h0 || busy_rb[0] !== 1'b0) begin
            n_err++;
            $display("FAIL x0_after cyc %0d: data=%h busy=%b data_b=%h busy_b=%b want 0", k, data_r[31:0], busy_r[0], data_rb[31:0], busy_rb[0]);
         end
         tick();
      end
   endtask

   task automatic test_scoreboard();
      resv_en = 1'b1; addr_rv = 5'd3;
      addr_r = {5'd0, 5'd0, 5'd3};
      addr_rb = {5'd0, 5'd3};
      #1;
      n_cmp++;
      if (busy_r[0] !== 1'b0) begin
         n_err++; $display("FAIL resv_not_yet: got %b want 0", busy_r[0]);
      end
      tick();
      resv_en = 1'b0;
      #1;
      n_cmp++;
      if (busy_r[0] !== 1'b1 || busy_rb[0] !== 1'b1) begin
         n_err++; $display("FAIL resv_busy: got %b/%b want 1/1", busy_r[0], busy_rb[0]);
      end
      wen = 1'b1; addr_w = 5'd3; data_w = 32'h000000A5;
      #1;
      n_cmp++;
      if (busy_r[0] !== 1'b1 || data_r[31:0] !== 32'h000000A5) begin
         n_err++; $display("FAIL wb_same_cycle: busy=%b data=%h want 1/000000a5", busy_r[0], data_r[31:0]);
      end
      tick();
      wen = 1'b0;
      #1;
      n_cmp++;
      if (busy_r[0] !== 1'b0 || busy_rb[0] !== 1'b0 || data_rb[31:0] !== 32'h000000A5) begin
         n_err++; $display("FAIL wb_after: busy=%b/%b data_b=%h want 0/0/000000a5", busy_r[0], busy_rb[0], data_rb[31:0]);
      end
      wen = 1'b1; addr_w = 5'd9; data_w = 32'h00000099;
      resv_en = 1'b1; addr_rv = 5'd9;
      addr_r = {5'd0, 5'd0, 5'd9};
      tick();
      wen = 1'b0; resv_en = 1'b0;
      #1;
      n_cmp++;
      if (busy_r[0] !== 1'b1 || data_r[31:0] !== 32'h00000099) begin
         n_err++; $display("FAIL wr_resv_same: busy=%b data=%h want 1/00000099", busy_r[0], data_r[31:0]);
      end
      resv_en = 1'b1; addr_rv = 5'd9;
      tick();
      resv_en = 1'b0;
      #1;
      n_cmp++;
      if (busy_r[0] !== 1'b1) begin
         n_err++; $display("FAIL resv_busy_again: got %b want 1", busy_r[0]);
      end
      wen = 1'b1; addr_w = 5'd12; data_w = 32'h0000000C;
      addr_r = {5'd0, 5'd0, 5'd12};
      tick();
      wen = 1'b0;
      #1;
      n_cmp++;
      if (busy_r[0] !== 1'b0 || data_r[31:0] !== 32'h0000000C) begin
         n_err++; $display("FAIL write_not_busy: busy=%b data=%h want 0/0000000c", busy_r[0], data_r[31:0]);
      end
   endtask

   task automatic test_multiport();
      wen = 1'b1; addr_w = 5'd1;  data_w = 32'h00000001; tick();
      addr_w = 5'd2;  data_w = 32'h00000004; tick();
      addr_w = 5'd31; data_w = 32'h80000000; tick();
      wen = 1'b0;
      addr_r = {5'd31, 5'd2, 5'd1};
      addr_rb = {5'd31, 5'd2};
      #1;
      n_cmp++;
      if (data_r !== {32'h80000000, 32'h00000004, 32'h00000001}) begin
         n_err++; $display("FAIL multiport_read: got %h want 800000000000000400000001", data_r);
      end
      n_cmp++;
      if (data_rb !== {32'h80000000, 32'h00000004}) begin
         n_err++; $display("FAIL multiport_read_b: got %h want 8000000000000004", data_rb);
      end
   endtask

   task automatic test_back_to_back();
      addr_w = 'x; addr_rv = 'x; data_w = 'x;
      tick(); tick();
      addr_r = {5'd3, 5'd9, 5'd7};
      #1;
      n_cmp++;
      if (data_r !== {32'h000000A5, 32'h00000099, 32'h12345678} || busy_r !== 3'b010) begin
         n_err++; $display("FAIL idle_x_addr: data=%h busy=%b want 000000a50000009912345678/010", data_r, busy_r);
      end
      wen = 1'b1; addr_w = 5'd7; data_w = 32'hCAFEF00D;
      tick();
      addr_w = 5'd7; data_w = 32'h0BADF00D;
      addr_rb = {5'd0, 5'd7};
      #1;
      n_cmp++;
      if (data_r[31:0] !== 32'h0BADF00D || data_rb[31:0] !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL b2b_write: got %h/%h want 0badf00d/cafef00d", data_r[31:0], data_rb[31:0]);
      end
      tick();
      wen = 1'b0;
      #1;
      n_cmp++;
      if (data_rb[31:0] !== 32'h0BADF00D) begin
         n_err++; $display("FAIL b2b_final: got %h want 0badf00d", data_rb[31:0]);
      end
   endtask

   initial begin
      test_reset();
      test_mid_clear();
      test_bypass();
      test_zero_reg();
      test_scoreboard();
      test_multiport();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised general-purpose register file for the RV32I core, and the successor to the single-write/dual-read register file.
- Adds configurable width, depth and read-port count, and a hardware zeroing sequence after reset.
- Adds optional write-to-read bypass and a per-register busy scoreboard, so the pipeline can detect RAW hazards on in-flight destinations.
- Sits between decode (read/reserve) and writeback (write).

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of registers; power of 2, at least 2. Localparam AW = clog2(NREGS).
- NREAD, 2, number of independent combinational read ports.
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and reserves.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst_n  input  1  reset, synchronous, active-low.
- AddrR  input  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- DataR  output  NREAD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN].
- BusyR  output  NREAD  busy bit of the register addressed by each read port.
- WEn  input  1  write enable.
- AddrW  input  AW  write address.
- DataW  input  XLEN  write data.
- ResvEn  input  1  reserve enable; marks AddrRv busy (pending writeback).
- AddrRv  input  AW  reserve address.
- Ready  output  1  high once the clear sequence is complete.

Behaviour:
- Reset and state: Rst_n is synchronous, active-low, one clock. Two-state FSM, CLEAR and RUN, with a clear counter cnt of width AW.
- Reset action: any posedge with Rst_n=0 sets state=CLEAR, cnt=0 and all busy bits=0. Array contents are not touched by reset itself.
- CLEAR:
  - Each posedge with Rst_n=1 writes 0 to entry cnt and increments cnt.
  - When entry NREGS-1 is written, state becomes RUN.
  - Clearing takes exactly NREGS cycles after reset release; Ready rises after the NREGS-th posedge.
  - Reset asserted mid-CLEAR restarts at cnt=0.
- While in CLEAR: Ready=0, every DataR=0, every BusyR=0, and WEn/ResvEn are ignored (no array or busy update).
- RUN: Ready=1. A write with WEn=1 updates the array at posedge, unless ZERO_REG=1 and AddrW=0.
- Reads are combinational, zero latency:
  - DataR[i] is the array value at AddrR[i].
  - It is forced to 0 when ZERO_REG=1 and AddrR[i]=0.
  - When BYPASS=1, WEn=1, AddrW=AddrR[i] and the write is not suppressed, DataR[i]=DataW in the same cycle.
  - When BYPASS=0, the new value is visible the cycle after the write.
- Scoreboard, updated at posedge in RUN only:
  - WEn clears busy[AddrW].
  - ResvEn sets busy[AddrRv].
  - If both hit the same address in the same cycle, the set wins and busy stays 1 (a newer producer was issued).
  - Register 0 is never busy when ZERO_REG=1.
  - Reserving an already-busy register leaves it busy.
  - Writing a non-busy register is legal and leaves it 0.
- BusyR[i] = busy[AddrR[i]], with no bypass: a write in the same cycle still shows busy=1 until the next cycle.
- No arithmetic on data. cnt wraps only at the CLEAR-to-RUN transition.
- X on an unused port's address must not corrupt state when its enable is 0.

Test Plan:
- Reset then clear: hold Rst_n=0 for 2 cycles, release. Ready=0 for 32 cycles and rises after the 32nd posedge. All 32 registers then read 0 and all BusyR=0.
- Mid-clear reset: release reset, assert Rst_n=0 at cycle 10, release again. Ready rises exactly 32 cycles after the second release. WEn=1 to x5 with 0xDEADBEEF during CLEAR leaves x5=0.
- Write/read with bypass: in RUN, WEn=1, AddrW=7, DataW=0x12345678, AddrR0=7 in the same cycle gives DataR0=0x12345678 combinationally. With BYPASS=0 it gives 0 that cycle and 0x12345678 the next.
- Zero register: write 0xFFFFFFFF to x0 and reserve x0. DataR0=0 at AddrR0=0 and BusyR0=0 on all subsequent cycles.
- Scoreboard: reserve x3, then read x3 → BusyR=1. Write x3=0xA5 → BusyR=1 that cycle, 0 the next, data 0xA5. A simultaneous write and reserve to x9 leaves BusyR=1.
- Multi-port: NREAD=3, write x1=1, x2=4, x31=0x80000000. Reading ports at 1, 2 and 31 in one cycle returns all three values independently.
